// File: rtl/cdc_pkg.sv
// Shared constants and sizing helpers for the clock-domain-crossing cores.
package cdc_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  // Bits needed to hold values 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer, reset to 0; q follows d after STAGES clk edges.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= STAGES'({chain, d});
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_recv.sv
// Recovers one event per toggle_in level change and queues it as a pending count.
// Latency: pulse/ack/pending update SYNC_STAGES+1 clk edges after toggle_in changes.
// Backpressure: evt_ready pops one event per cycle; edges arriving at saturation set sticky overflow.
module toggle_recv
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_in,
  output logic             pulse_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             ack_out,
  output logic             overflow,
  input  logic             ovf_clr
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("toggle_recv: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
    end
  endgenerate

  localparam int                   ARM_W    = clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]     ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]     PEND_MAX = '1;

  logic             s;
  logic             prev;
  logic             armed;
  logic [ARM_W-1:0] arm_cnt;
  logic             edge_det;
  logic             inc;
  logic             dec;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (toggle_in),
    .q   (s)
  );

  // prev absorbs the settled level for SYNC_STAGES+1 edges before detection
  // is enabled, so a level of 1 at reset release is not mistaken for an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
      if (arm_cnt == ARM_LAST) armed <= 1'b1;
    end
  end

  assign edge_det  = armed & (s ^ prev);
  assign evt_valid = (pending != '0);
  assign inc       = edge_det;
  assign dec       = evt_valid & evt_ready;
  assign ack_out   = prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      prev      <= s;
      pulse_out <= edge_det;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10:   if (pending != PEND_MAX) pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
      // A dropped edge outranks a same-cycle clear so it is never missed.
      if (inc && !dec && pending == PEND_MAX) overflow <= 1'b1;
      else if (ovf_clr)                       overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_recv.sv
// Randomized and directed bench for toggle_recv against an event-history reference model.
module tb_toggle_recv;

  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int PMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          toggle_in = 1'b0;
  logic          evt_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          pulse_out;
  logic          evt_valid;
  logic [CW-1:0] pending;
  logic          ack_out;
  logic          overflow;

  toggle_recv #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .toggle_in (toggle_in),
    .pulse_out (pulse_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .ack_out   (ack_out),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: toggle_in level seen at each clk edge since reset release.
  // The destination sees level k after SYNC edges of delay; an event is a level
  // change observed once the receiver has been out of reset long enough to arm.
  bit lvls[$];
  int ncyc;
  int m_pend;
  bit m_ovf, m_pulse, m_ack;

  function automatic bit lvl_at(input int k);
    return (k >= 1) ? lvls[k-1] : 1'b0;
  endfunction

  task automatic model_reset();
    lvls.delete();
    ncyc    = 0;
    m_pend  = 0;
    m_ovf   = 0;
    m_pulse = 0;
    m_ack   = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      bit ev, pop, dropped;
      ncyc++;
      lvls.push_back(toggle_in);
      m_ack   = lvl_at(ncyc - SYNC);
      ev      = (ncyc >= SYNC + 2) && (lvl_at(ncyc - SYNC) != lvl_at(ncyc - SYNC - 1));
      pop     = (m_pend != 0) && evt_ready;
      dropped = ev && !pop && (m_pend == PMAX);
      if (ev && !pop && m_pend < PMAX) m_pend++;
      else if (!ev && pop)             m_pend--;
      if (dropped)      m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_pulse = ev;
    end
  end

  always @(negedge clk) begin
    check("pulse", pulse_out, m_pulse);
    check("pending", pending, m_pend);
    check("valid", evt_valid, m_pend != 0);
    check("ack", ack_out, m_ack);
    check("overflow", overflow, m_ovf);
    if (pulse_out) pulse_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flip();
    toggle_in = ~toggle_in;
  endtask

  initial begin
    int pc;
    model_reset();
    cyc(2);
    check("rst_pending", pending, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_ack", ack_out, 0);
    rst = 1'b0;
    cyc(6);

    // Single event: three edges from flip to pulse.
    flip();
    cyc(1); check("lat_e1", pulse_out, 0);
    cyc(1); check("lat_e2", pulse_out, 0);
    cyc(1); check("lat_e3", pulse_out, 1);
    check("single_pend", pending, 1);
    check("single_valid", evt_valid, 1);
    check("single_ack", ack_out, 1);
    cyc(1); check("pulse_one_cycle", pulse_out, 0);

    // Drain from 3 with no underflow.
    flip(); cyc(5);
    flip(); cyc(5);
    check("drain_start", pending, 3);
    evt_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      check("drain", pending, (3 - i > 0) ? 3 - i : 0);
    end
    check("drain_valid", evt_valid, 0);
    evt_ready = 1'b0;

    // Saturation.
    pc = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("ovf_before16", overflow, 0);
      flip(); cyc(5);
    end
    check("sat_pend", pending, PMAX);
    check("sat_ovf", overflow, 1);
    check("sat_pulses", pulse_cnt - pc, 16);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Edge and pop in the same cycle at saturation.
    flip(); cyc(2);
    evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    check("simul_pulse", pulse_out, 1);
    check("simul_pend", pending, PMAX);
    check("simul_ovf", overflow, 0);
    cyc(2);

    // Build pending=5 with overflow set, then reset between edges.
    flip(); cyc(5);
    check("pre_ovf", overflow, 1);
    evt_ready = 1'b1; cyc(10); evt_ready = 1'b0;
    check("pre_pend", pending, 5);
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_pend", pending, 0);
    check("async_ovf", overflow, 0);
    check("async_valid", evt_valid, 0);
    check("async_ack", ack_out, 0);
    check("async_pulse", pulse_out, 0);
    check("tin_high", toggle_in, 1);
    cyc(2);
    pc = pulse_cnt;
    rst = 1'b0;
    cyc(3);
    check("rel_ack", ack_out, 1);
    check("rel_pend", pending, 0);
    cyc(7);
    check("rel_no_pulse", pulse_cnt - pc, 0);
    flip(); cyc(5);
    check("rel_one_evt", pulse_cnt - pc, 1);
    check("rel_pend1", pending, 1);

    // Random traffic; source only toggles once its previous level is acknowledged.
    for (int i = 0; i < 3000; i++) begin
      evt_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if (toggle_in == m_ack && $urandom_range(0, 2) == 0) flip();
      cyc(1);
    end
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
